card_dealer: RTL

Card source for the card-game datapath. Holds a 52-card deck as a dealt-mask, and on each request deals one not-yet-dealt card as a 6-bit card index (0..51). Downstream, the index decodes as suit = index / 13 and rank = index % 13. The dealer never repeats a card until the deck is reshuffled.

---
 rtl/card_pkg.sv | 34 +++
 rtl/card_dealer_if.sv | 26 ++
 rtl/card_lfsr.sv | 26 ++
 rtl/card_dealer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// card_pkg: deck geometry, card index type, dealer state encoding and
// the suit/rank helpers shared with the downstream decode.
package card_pkg;

  localparam int SUITS     = 4;
  localparam int RANKS     = 13;
  localparam int DECK_SIZE = SUITS * RANKS;

  typedef logic [5:0] card_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } dealer_state_t;

  // suit = index / RANKS
  function automatic logic [1:0] card_suit(card_t c);
    return 2'(int'(c) / RANKS);
  endfunction

  // rank = index % RANKS
  function automatic logic [3:0] card_rank(card_t c);
    return 4'(int'(c) % RANKS);
  endfunction

  // Fold a raw 6-bit value into 0..deck-1 with a single subtraction.
  // The raw value is < 64, so one fold is enough for any deck of 32 or more.
  function automatic card_t wrap_start(logic [5:0] v, int deck);
    if (int'(v) >= deck) return card_t'(int'(v) - deck);
    return v;
  endfunction

endpackage

// File: rtl/card_dealer_if.sv
// card_dealer_if: request/response bundle between a requester (master)
// and the card dealer (slave).
interface card_dealer_if
  import card_pkg::*;
();

  logic       shuffle;
  logic       deal_req;
  logic       busy;
  card_t      card_bit;
  logic       card_valid;
  logic       deal_err;
  logic [5:0] cards_left;
  logic       deck_empty;

  modport master (
    output shuffle, deal_req,
    input  busy, card_bit, card_valid, deal_err, cards_left, deck_empty
  );

  modport slave (
    input  shuffle, deal_req,
    output busy, card_bit, card_valid, deal_err, cards_left, deck_empty
  );

endinterface

// File: rtl/card_lfsr.sv
// card_lfsr: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left
// every cycle out of reset. SEED must be non-zero or the sequence locks up.
module card_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q, lfsr_d;

  // Taps 16,14,13,11 map to bits 15,13,12,10; feedback enters at bit 0.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Free-running state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/card_dealer.sv
// card_dealer: deals one not-yet-dealt card index per request from a
// dealt-mask, probing one slot per cycle from a start index and wrapping
// at the end of the deck. Every output is a flop.
//
// Build option CARD_DEALER_LFSR_EN: when defined, the start index comes
// from a free-running LFSR (pseudo-random deal order); when undefined the
// start index is 0 and cards come out in ascending order.
module card_dealer
  import card_pkg::*;
#(
  parameter int          SUITS     = card_pkg::SUITS,
  parameter int          RANKS     = card_pkg::RANKS,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst_n,
  card_dealer_if.slave bus
);

  localparam int         DECK     = SUITS * RANKS;
  localparam card_t      LAST_IDX = card_t'(DECK - 1);
  localparam logic [5:0] FULL_CNT = 6'(DECK);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] SEARCH = ST_SEARCH;
  localparam logic [1:0] DONE   = ST_DONE;

  logic [1:0]      state_q, state_d;
  card_t           probe_q, probe_d;
  logic [DECK-1:0] dealt_q, dealt_d;
  logic [5:0]      left_q,  left_d;
  card_t           card_q,  card_d;
  logic            valid_q, valid_d;
  logic            err_q,   err_d;
  logic            busy_q,  busy_d;
  logic            empty_q, empty_d;

  card_t           start_idx;

`ifdef CARD_DEALER_LFSR_EN
  logic [15:0] lfsr;
  logic        unused_lfsr_hi;

  card_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr)
  );

  // Low six LFSR bits, folded into the deck range.
  assign start_idx      = wrap_start(lfsr[5:0], DECK);
  assign unused_lfsr_hi = ^lfsr[15:6];
`else
  logic unused_seed;

  // Deterministic order: always start probing at slot 0.
  assign start_idx   = '0;
  assign unused_seed = ^LFSR_SEED;
`endif

  // Next-state: request acceptance, linear probe search, one-cycle DONE,
  // with shuffle overriding everything except the last dealt card index.
  always_comb begin
    state_d = state_q;
    probe_d = probe_q;
    dealt_d = dealt_q;
    left_d  = left_q;
    card_d  = card_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.deal_req) begin
          if (left_q == '0) begin
            err_d = 1'b1;
          end else begin
            probe_d = start_idx;
            state_d = SEARCH;
          end
        end
      end
      SEARCH: begin
        // A free slot always exists here: IDLE only leaves with cards left.
        if (!dealt_q[probe_q]) begin
          dealt_d[probe_q] = 1'b1;
          card_d           = probe_q;
          left_d           = left_q - 6'd1;
          valid_d          = 1'b1;
          state_d          = DONE;
        end else begin
          probe_d = (probe_q == LAST_IDX) ? card_t'(0) : probe_q + card_t'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Shuffle aborts any search and drops a coincident request.
    if (bus.shuffle) begin
      dealt_d = '0;
      left_d  = FULL_CNT;
      card_d  = card_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      state_d = IDLE;
    end
  end

  // Status outputs are registered copies of the next-state view.
  always_comb begin
    busy_d  = (state_d != IDLE);
    empty_d = (left_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      probe_q <= '0;
      dealt_q <= '0;
      left_q  <= FULL_CNT;
      card_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      probe_q <= probe_d;
      dealt_q <= dealt_d;
      left_q  <= left_d;
      card_q  <= card_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      empty_q <= empty_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.card_bit   = card_q;
  assign bus.card_valid = valid_q;
  assign bus.deal_err   = err_q;
  assign bus.cards_left = left_q;
  assign bus.deck_empty = empty_q;

endmodule
